// File: rtl/game_state_rx_if.sv
// Received-word bus from the UART word assembler into the game-state decoder.
interface game_state_rx_if;
  logic [15:0] data;
  logic        conv8to16valid;

  modport master (output data, output conv8to16valid);
  modport slave  (input  data, input  conv8to16valid);
endinterface

// File: rtl/game_state_rx.sv
// Game-state stream decoder: collects a five-word tagged frame into shadow
// registers and commits every field to the outputs in a single edge.
module game_state_rx #(
  parameter int LINK_TIMEOUT = 6_500_000,
  parameter int WORD_TIMEOUT = 65_000
) (
  input  logic                  clk,
  input  logic                  rst,
  game_state_rx_if.slave        bus,
  output logic [11:0]           pl1_posx,
  output logic [11:0]           pl1_posy,
  output logic [11:0]           ball_posx,
  output logic [11:0]           ball_posy,
  output logic [3:0]            pl1_score,
  output logic [3:0]            pl2_score,
  output logic                  flag_point,
  output logic                  end_game,
  output logic                  whistle,
  output logic                  frame_valid,
  output logic                  link_up,
  output logic [7:0]            err_cnt
);

  localparam int WCW = $clog2(WORD_TIMEOUT + 1);
  localparam int LCW = $clog2(LINK_TIMEOUT + 1);

  typedef enum logic [2:0] {HUNT, W2, W3, W4, W5} state_e;

  state_e      state_q;
  logic [WCW-1:0] wcnt_q;
  logic [LCW-1:0] lcnt_q;
  logic [11:0] sh_px_q, sh_py_q, sh_bx_q, sh_by_q;
  logic [11:0] px_q, py_q, bx_q, by_q;
  logic [3:0]  s1_q, s2_q;
  logic        fp_q, eg_q, wh_q, fv_q, link_q;
  logic [7:0]  err_q, err_d;

  logic [3:0]  tag;
  logic [11:0] payload;
  logic [3:0]  exp_tag;
  logic        vld;
  logic        word_to;
  logic        unused_rsvd;

  always_comb begin
    tag     = bus.data[15:12];
    payload = bus.data[11:0];
    vld     = bus.conv8to16valid;
    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    exp_tag = 4'd0;
    case (state_q)
      W2:      exp_tag = 4'd2;
      W3:      exp_tag = 4'd3;
      W4:      exp_tag = 4'd4;
      W5:      exp_tag = 4'd5;
      default: exp_tag = 4'd1;
    endcase
    // The counter is compared one short of the limit so the abort lands on
    // the edge where the count would reach WORD_TIMEOUT; a word there still wins.
    word_to = (state_q != HUNT) && !vld && (wcnt_q == WCW'(WORD_TIMEOUT - 1));
  end

  assign unused_rsvd = bus.data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      sh_px_q <= '0;
      sh_py_q <= '0;
      sh_bx_q <= '0;
      sh_by_q <= '0;
      px_q    <= 12'd50;
      py_q    <= 12'd679;
      bx_q    <= '0;
      by_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      fp_q    <= 1'b0;
      eg_q    <= 1'b0;
      wh_q    <= 1'b0;
      fv_q    <= 1'b0;
      link_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      fv_q <= 1'b0;
      wh_q <= 1'b0;

      if (lcnt_q < LCW'(LINK_TIMEOUT)) begin
        lcnt_q <= lcnt_q + LCW'(1);
        if (lcnt_q == LCW'(LINK_TIMEOUT - 1)) link_q <= 1'b0;
      end

      if (state_q == HUNT || vld || word_to) wcnt_q <= '0;
      else                                   wcnt_q <= wcnt_q + WCW'(1);

      if (vld) begin
        if (state_q == HUNT) begin
          if (tag == 4'd1) begin
            sh_px_q <= payload;
            state_q <= W2;
          end
        end else if (tag == exp_tag) begin
          case (state_q)
            W2: begin sh_py_q <= payload; state_q <= W3; end
            W3: begin sh_bx_q <= payload; state_q <= W4; end
            W4: begin sh_by_q <= payload; state_q <= W5; end
            W5: begin
              // Commit overrides the link-timeout update above.
              px_q    <= sh_px_q;
              py_q    <= sh_py_q;
              bx_q    <= sh_bx_q;
              by_q    <= sh_by_q;
              s1_q    <= payload[11:8];
              s2_q    <= payload[7:4];
              fp_q    <= payload[3];
              eg_q    <= payload[2];
              wh_q    <= payload[1];
              fv_q    <= 1'b1;
              lcnt_q  <= '0;
              link_q  <= 1'b1;
              state_q <= HUNT;
            end
            default: state_q <= HUNT;
          endcase
        end else if (tag == 4'd1) begin
          err_q   <= err_d;
          sh_px_q <= payload;
          state_q <= W2;
        end else begin
          err_q   <= err_d;
          state_q <= HUNT;
        end
      end else if (word_to) begin
        err_q   <= err_d;
        state_q <= HUNT;
      end
    end
  end

  assign pl1_posx    = px_q;
  assign pl1_posy    = py_q;
  assign ball_posx   = bx_q;
  assign ball_posy   = by_q;
  assign pl1_score   = s1_q;
  assign pl2_score   = s2_q;
  assign flag_point  = fp_q;
  assign end_game    = eg_q;
  assign whistle     = wh_q;
  assign frame_valid = fv_q;
  assign link_up     = link_q;
  assign err_cnt     = err_q;

endmodule

// File: doc/game_state_rx.md
# game_state_rx

Receive-side decoder for the game-state stream that the player-1 board transmits over UART. It sits on the player-2 board between `uart` (16-bit word output, `conv8to16valid` strobe) and the drawing and score logic. It collects one five-word frame into shadow registers, checks tag order, and commits all fields atomically. It also reports frame completion, the whistle event, link status and an error count.

## Interface
Parameters:
- `LINK_TIMEOUT`, default 6_500_000: cycles without a committed frame before `link_up` drops (100 ms at 65 MHz).
- `WORD_TIMEOUT`, default 65_000: maximum cycles between consecutive words inside one frame (1 ms).

Ports:
- `clk` in 1: pixel clock, 65 MHz.
- `rst` in 1: reset, asynchronous and active-low.
- `data` in 16: received word, `{tag[15:12], payload[11:0]}`.
- `conv8to16valid` in 1: `data` is valid this cycle; one-cycle strobe.
- `pl1_posx`, `pl1_posy` out 12: remote player position.
- `ball_posx`, `ball_posy` out 12: ball position.
- `pl1_score`, `pl2_score` out 4: scores.
- `flag_point`, `end_game` out 1: level flags.
- `whistle` out 1: one-cycle pulse.
- `frame_valid` out 1: one-cycle pulse on each commit.
- `link_up` out 1: a frame was committed within the last `LINK_TIMEOUT` cycles.
- `err_cnt` out 8: saturating count of discarded frames.

## Operation
- Tags:
  - 1: `pl1_posx` = `payload`.
  - 2: `pl1_posy` = `payload`.
  - 3: `ball_posx` = `payload`.
  - 4: `ball_posy` = `payload`.
  - 5: `payload[11:8]` = `pl1_score`, `payload[7:4]` = `pl2_score`, `payload[3]` = `flag_point`, `payload[2]` = `end_game`, `payload[1]` = `whistle`, `payload[0]` reserved and ignored.
  - Tags 0 and 6–15 are illegal.
- FSM states: `HUNT`, `W2`, `W3`, `W4`, `W5`.
  - `HUNT`: a word with tag 1 loads the shadow register and goes to `W2`. Any other word is dropped silently with no error.
  - `Wn` (n = 2..5): a word with tag n loads its shadow register. `W2`–`W4` advance to the next state. `W5` commits and returns to `HUNT`.
  - `Wn`, word with tag 1: resync. `err_cnt` += 1, the word loads shadow `pl1_posx`, go to `W2`.
  - `Wn`, any other tag, including illegal tags: `err_cnt` += 1, go to `HUNT`.
- Commit:
  - All eight output fields are loaded from shadow registers (tag-5 fields taken directly from `payload`) in the same edge.
  - `frame_valid` pulses.
  - `whistle` pulses only when `payload[1]` = 1.
  - The link counter reloads to 0 and `link_up` goes to 1.
- Word timeout: a word counter clears on every accepted word. In `W2`–`W5`, reaching `WORD_TIMEOUT` gives `err_cnt` += 1 and a return to `HUNT`. The counter is idle in `HUNT`.
- Link timeout: the link counter increments while below `LINK_TIMEOUT`. On reaching `LINK_TIMEOUT`, `link_up` goes to 0. Outputs hold their last committed values.
- `err_cnt` saturates at 255 and clears only on reset.
- Widths: the counters are just wide enough for their parameter (`$clog2(X+1)`). Payloads are taken verbatim with no range check; range clamping belongs to consumers.

## Timing
- Reset values (while `rst` = 0, asynchronously):
  - `pl1_posx` = 50, `pl1_posy` = 679.
  - `ball_posx` = 0, `ball_posy` = 0.
  - Scores = 0, all flags = 0, `whistle` = 0, `frame_valid` = 0.
  - `link_up` = 0, `err_cnt` = 0.
  - FSM = `HUNT`, all counters = 0, shadow registers = 0.
- Latency: outputs, `frame_valid` and `whistle` change at the first edge after the edge that samples the tag-5 word, i.e. one cycle after the tag-5 `conv8to16valid`. No partial frame is ever visible on the outputs.
- Words may arrive back-to-back (valid on consecutive cycles); no gap is required.
- Same-cycle word arrival and word timeout: the word wins and is processed normally.
- Same-cycle commit and link timeout: the commit wins and `link_up` stays 1.
- Reset asserted mid-frame: the frame is discarded, no error is counted, and the outputs return to their reset values.
- `frame_valid` and `whistle` are never high for more than one cycle per commit.

## Test plan
- Clean frame: words 0x1064, 0x22A7, 0x3200, 0x4150, 0x5316 sent back-to-back. One cycle after the last word: `pl1_posx`=100, `pl1_posy`=679, `ball_posx`=512, `ball_posy`=336, `pl1_score`=3, `pl2_score`=1, `flag_point`=0, `end_game`=1, `whistle` pulses once, `frame_valid` pulses once, `link_up`=1, `err_cnt`=0.
- Out of order: 0x1064, 0x3200 → `err_cnt`=1, FSM in `HUNT`. Then a full frame with `pl1_posx` = 0x0C8 → outputs update, `pl1_posx`=200.
- Resync: 0x1064, 0x22A7, 0x10C8, 0x22A7, 0x3200, 0x4150, 0x5000 → `err_cnt`=1, `pl1_posx`=200, exactly one `frame_valid`, no `whistle`.
- Word timeout (`WORD_TIMEOUT` = 16): 0x1064, 0x22A7, then 16 idle cycles, then 0x3200 → `err_cnt`=1. The 0x3200 is ignored in `HUNT` and the outputs are unchanged.
- Link loss (`LINK_TIMEOUT` = 100): one good frame, then 100 idle cycles → `link_up` = 0 while outputs hold. Another frame → `link_up` = 1.
- Async reset asserted between the tag-3 and tag-4 words → outputs take reset values immediately. After release, 0x4150, 0x5000 produce no commit and no error.
